mips_lsu: RTL and testbench

Load/store unit sitting directly upstream of datamemory in the MIPS MEM stage. Converts byte-addressed MIPS memory ops (LW/LH/LHU/LB/LBU/SW/SH/SB) into word accesses on the datamemory port (ADDR, RW_RD, din, dout). Performs sign/zero extension for loads and read-modify-write for sub-word stores, since datamemory is word-wide only. Uses a start/busy/done handshake toward the pipeline control.

---
 rtl/mips_mem_defs.sv | 45 ++++
 rtl/lsu_lane.sv | 56 +++++
 rtl/mips_lsu.sv | 147 ++++++++++++++
 tb/tb_mips_lsu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_defs.sv
// Shared definitions for the MIPS MEM-stage load/store path.
// Provides the op encodings, the LSU FSM state encoding, default widths
// and the alignment/class helpers used by mips_lsu and lsu_lane.
package mips_mem_defs;

    localparam int unsigned LSU_DATA_WIDTH = 32;
    localparam int unsigned LSU_ADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Word ops need offset 0, halfword ops need an even offset, bytes never fault.
    function automatic logic is_misaligned(input op_t op, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LW, OP_SW:          mis = (offset != 2'b00);
            OP_LH, OP_LHU, OP_SH:  mis = offset[0];
            default:               mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_load(input op_t op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for a 32-bit little-endian word.
// Ports:
//   op         - memory op encoding
//   offset     - byte offset within the word (0 = bits [7:0])
//   word_in    - word read from memory
//   wdata      - store data (SH uses [15:0], SB uses [7:0])
//   load_val   - extracted and sign/zero-extended load result
//   store_word - word_in with the store lane(s) replaced (SW: wdata)
module lsu_lane
    import mips_mem_defs::*;
(
    input  op_t         op,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] mask_b;
    logic [31:0] mask_h;

    assign byte_sh = {offset, 3'b000};
    assign half_sh = {offset[1], 4'b0000};
    assign lane_b  = 8'(word_in >> byte_sh);
    assign lane_h  = 16'(word_in >> half_sh);
    assign mask_b  = 32'h0000_00FF << byte_sh;
    assign mask_h  = 32'h0000_FFFF << half_sh;

    // Load extraction and extension.
    always_comb begin
        load_val = word_in;
        case (op)
            OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_val = {16'h0000, lane_h};
            OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_val = {24'h00_0000, lane_b};
            default: load_val = word_in;
        endcase
    end

    // Read-modify-write merge for sub-word stores.
    always_comb begin
        store_word = wdata;
        case (op)
            OP_SH:   store_word = (word_in & ~mask_h) | (32'(wdata[15:0]) << half_sh);
            OP_SB:   store_word = (word_in & ~mask_b) | (32'(wdata[7:0]) << byte_sh);
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// MIPS MEM-stage load/store unit in front of a word-wide datamemory.
// Turns byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB into word reads/writes,
// extends loads and performs read-modify-write for sub-word stores.
// Ports:
//   CLK, RST           - clock, synchronous active-high reset
//   start, op, addr,   - request (sampled only when idle)
//   wdata
//   busy, done,        - handshake; misaligned pulses with done on a fault
//   misaligned
//   rdata              - last completed load result
//   mem_ADDR, mem_RW_RD, mem_din, mem_dout - datamemory port
module mips_lsu
    import mips_mem_defs::*;
#(
    parameter int unsigned DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = LSU_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_ADDR,
    output logic                  mem_RW_RD,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    state_t                state, state_nxt;
    op_t                   req_op, req_op_nxt;
    logic [1:0]            req_off, req_off_nxt;
    logic [DATA_WIDTH-1:0] req_wdata, req_wdata_nxt;
    logic                  err, err_nxt;

    logic                  busy_nxt, done_nxt, misaligned_nxt, rw_rd_nxt;
    logic [DATA_WIDTH-1:0] rdata_nxt, din_nxt;
    logic [ADDR_WIDTH-1:0] maddr_nxt;

    logic [31:0]           load_val, store_word;
    op_t                   in_op;
    logic                  in_mis;

    // Address bits above the 4 KiB window wrap and are intentionally dropped.
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    assign in_op  = op_t'(op);
    assign in_mis = is_misaligned(in_op, addr[1:0]);

    lsu_lane u_lane (
        .op         (req_op),
        .offset     (req_off),
        .word_in    (mem_dout),
        .wdata      (req_wdata),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            req_op     <= OP_LW;
            req_off    <= 2'b00;
            req_wdata  <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            rdata      <= '0;
            mem_ADDR   <= '0;
            mem_RW_RD  <= 1'b1;
            mem_din    <= '0;
        end else begin
            state      <= state_nxt;
            req_op     <= req_op_nxt;
            req_off    <= req_off_nxt;
            req_wdata  <= req_wdata_nxt;
            err        <= err_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            misaligned <= misaligned_nxt;
            rdata      <= rdata_nxt;
            mem_ADDR   <= maddr_nxt;
            mem_RW_RD  <= rw_rd_nxt;
            mem_din    <= din_nxt;
        end
    end

    // Next state; outputs are decoded from the next state so they are Moore in it.
    always_comb begin
        state_nxt     = state;
        req_op_nxt    = req_op;
        req_off_nxt   = req_off;
        req_wdata_nxt = req_wdata;
        err_nxt       = err;
        rdata_nxt     = rdata;
        maddr_nxt     = mem_ADDR;
        din_nxt       = mem_din;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    req_op_nxt    = in_op;
                    req_off_nxt   = addr[1:0];
                    req_wdata_nxt = wdata;
                    err_nxt       = in_mis;
                    if (in_mis) begin
                        state_nxt = ST_DONE;
                    end else begin
                        maddr_nxt = addr[ADDR_WIDTH+1:2];
                        if (in_op == OP_SW) begin
                            din_nxt   = wdata;
                            state_nxt = ST_WR;
                        end else begin
                            state_nxt = ST_RD;
                        end
                    end
                end
            end
            ST_RD:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (is_load(req_op)) begin
                    rdata_nxt = load_val;
                    state_nxt = ST_DONE;
                end else begin
                    din_nxt   = store_word;
                    state_nxt = ST_WR;
                end
            end
            ST_WR:   state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt       = (state_nxt != ST_IDLE);
        done_nxt       = (state_nxt == ST_DONE);
        misaligned_nxt = (state_nxt == ST_DONE) && err_nxt;
        rw_rd_nxt      = (state_nxt != ST_WR);
    end

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu with a word-wide datamemory model and a
// byte-array reference memory.
module tb_mips_lsu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, misaligned;
    logic [31:0] rdata;
    logic [9:0]  mem_ADDR;
    logic        mem_RW_RD;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    always #5 CLK = ~CLK;

    mips_lsu dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .rdata      (rdata),
        .mem_ADDR   (mem_ADDR),
        .mem_RW_RD  (mem_RW_RD),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    logic [7:0]  ref_mem [4096];
    logic [31:0] dmem [1024];
    logic        mem_load;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata;

    // Datamemory: registered read, write on the edge when RW_RD=0.
    always @(posedge CLK) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++)
                dmem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        end else if (!mem_RW_RD) begin
            dmem[mem_ADDR] <= mem_din;
        end
        mem_dout <= dmem[mem_ADDR];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & 'hFFC;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] ad);
        int a, v;
        a = int'(ad & 32'hFFF);
        v = 0;
        case (o)
            3'd0: return ref_word(a);
            3'd1, 3'd2: begin
                v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]);
                if (o == 3'd1 && v >= 32768) v -= 65536;
            end
            default: begin
                v = int'(ref_mem[a]);
                if (o == 3'd3 && v >= 128) v -= 256;
            end
        endcase
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [2:0] o, input logic [31:0] ad, input logic [31:0] wd);
        int a, n;
        a = int'(ad & 32'hFFF);
        n = (o == 3'd5) ? 4 : (o == 3'd6) ? 2 : 1;
        for (int k = 0; k < n; k++) ref_mem[a+k] = wd[8*k +: 8];
    endtask

    function automatic logic ref_mis(input logic [2:0] o, input logic [31:0] ad);
        if (o == 3'd0 || o == 3'd5) return ad[1:0] != 2'b00;
        if (o == 3'd1 || o == 3'd2 || o == 3'd6) return ad[0];
        return 1'b0;
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic mis);
        if (mis) return 1;
        if (o == 3'd5) return 2;
        if (o <= 3'd4) return 3;
        return 4;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_mis"},   32'(misaligned), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_maddr"}, 32'(mem_ADDR), 32'd0);
        check({tag, "_rw"},    32'(mem_RW_RD), 32'd1);
        check({tag, "_din"},   mem_din, 32'd0);
    endtask

    // Issue one request (called #1 after an edge with the DUT idle).
    task automatic do_op(input logic [2:0] o, input logic [31:0] ad, input logic [31:0] wd,
                         input bit noise);
        logic        mis, is_st;
        logic [31:0] new_rdata, exp_word;
        int          cyc, writes;
        mis    = ref_mis(o, ad);
        is_st  = (o >= 3'd5);
        writes = 0;
        new_rdata = exp_rdata;
        exp_word  = 32'd0;
        if (!mis && !is_st) new_rdata = ref_load(o, ad);
        if (!mis && is_st) begin
            ref_store(o, ad, wd);
            exp_word = ref_word(int'(ad & 32'hFFF));
        end
        start = 1'b1; op = o; addr = ad; wdata = wd;
        @(posedge CLK); #1;
        cyc = 1;
        while (!done && cyc < 10) begin
            if (!mem_RW_RD) begin
                writes++;
                check("wr_addr", 32'(mem_ADDR), (ad >> 2) & 32'h3FF);
                check("wr_data", mem_din, exp_word);
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                op = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        exp_rdata = new_rdata;
        check("latency", 32'(cyc), 32'(ref_lat(o, mis)));
        check("misaligned", 32'(misaligned), 32'(mis));
        check("rdata", rdata, exp_rdata);
        check("writes", 32'(writes), (is_st && !mis) ? 32'd1 : 32'd0);
        // A start presented alongside done must be ignored.
        start = 1'b1; op = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
        @(posedge CLK); #1;
        start = 1'b0;
        check("done_once", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    // Start a request and assert RST while the FSM is in cycle rst_cyc.
    task automatic reset_in(input logic [2:0] o, input logic [31:0] ad, input logic [31:0] wd,
                            input int rst_cyc);
        int cyc;
        start = 1'b1; op = o; addr = ad; wdata = wd;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < rst_cyc) begin
            @(posedge CLK); #1;
            cyc++;
        end
        // Only a write already in WR commits at the reset edge.
        if (!mem_RW_RD) ref_store(o, ad, wd);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_rdata = 32'd0;
        check_reset_values("rst_abort");
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        RST = 1'b1; start = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        mem_load = 1'b1;
        exp_rdata = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        mem_load = 1'b0;
        check_reset_values("reset");
        RST = 1'b0;
        @(posedge CLK); #1;

        do_op(3'd5, 32'h10, 32'hDEADBEEF, 1'b0);
        do_op(3'd0, 32'h10, 32'h0, 1'b0);
        check("tp_lw", rdata, 32'hDEADBEEF);
        do_op(3'd3, 32'h13, 32'h0, 1'b0);
        check("tp_lb", rdata, 32'hFFFFFFDE);
        do_op(3'd4, 32'h13, 32'h0, 1'b0);
        check("tp_lbu", rdata, 32'h000000DE);
        do_op(3'd1, 32'h12, 32'h0, 1'b0);
        check("tp_lh", rdata, 32'hFFFFDEAD);
        do_op(3'd2, 32'h10, 32'h0, 1'b0);
        check("tp_lhu", rdata, 32'h0000BEEF);
        do_op(3'd7, 32'h11, 32'h000000AA, 1'b0);
        check("tp_sb", ref_word(32'h10), 32'hDEADAAEF);
        do_op(3'd6, 32'h12, 32'h00001234, 1'b0);
        check("tp_sh", ref_word(32'h10), 32'h1234AAEF);
        do_op(3'd0, 32'h12, 32'h0, 1'b0);
        do_op(3'd6, 32'h11, 32'hFFFF, 1'b0);
        check("tp_mis_rdata", rdata, 32'h0000BEEF);
        do_op(3'd5, 32'h1000, 32'h55, 1'b1);
        reset_in(3'd7, 32'h20, 32'h77, 2);
        do_op(3'd0, 32'h20, 32'h0, 1'b0);
        reset_in(3'd5, 32'h24, 32'hCAFEF00D, 1);
        do_op(3'd0, 32'h24, 32'h0, 1'b0);
        check("tp_rst_wr", rdata, 32'hCAFEF00D);

        for (int n = 0; n < 300; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) ra |= ($urandom & 32'hFFFFF000);
            do_op(ro, ra, $urandom, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 1024; i++) check("mem_word", dmem[i], ref_word(4*i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
